// File: rtl/gerador_sequencia_lampadas.sv
// Lamp-sequence generator: replays three latched 2-bit lamp codes a programmable number of
// times, holding each code HOLD cycles with GAP idle cycles of code 00 between codes.
module gerador_sequencia_lampadas #(
    parameter int unsigned HOLD = 1,
    parameter int unsigned GAP  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] code0,
    input  logic [1:0] code1,
    input  logic [1:0] code2,
    input  logic [3:0] reps,
    output logic [1:0] out_code,
    output logic       code_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] HoldMax = 8'(HOLD);
    localparam logic [7:0] GapMax  = 8'(GAP);

    typedef enum logic [1:0] {StIdle, StEmit, StGap, StDone} state_e;

    state_e     state_q, state_d;
    logic [1:0] code0_q, code0_d;
    logic [1:0] code1_q, code1_d;
    logic [1:0] code2_q, code2_d;
    logic [3:0] reps_q, reps_d;
    logic [1:0] step_q, step_d;
    logic [4:0] rep_q, rep_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] gap_q, gap_d;

    logic [1:0] step_adv;
    logic [4:0] rep_adv;
    logic       last_step;

    logic [1:0] out_code_d;
    logic       code_valid_d;
    logic       busy_d;
    logic       done_d;

    always_comb begin
        state_d = state_q;
        code0_d = code0_q;
        code1_d = code1_q;
        code2_d = code2_q;
        reps_d  = reps_q;
        step_d  = step_q;
        rep_d   = rep_q;
        hold_d  = hold_q;
        gap_d   = gap_q;

        // Next step position; step 2 wraps to 0 and opens a new repetition
        if (step_q == 2'd2) begin
            step_adv = 2'd0;
            rep_adv  = rep_q + 5'd1;
        end else begin
            step_adv = step_q + 2'd1;
            rep_adv  = rep_q;
        end
        last_step = (step_q == 2'd2) && (rep_q == {1'b0, reps_q});

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    code0_d = code0;
                    code1_d = code1;
                    code2_d = code2;
                    reps_d  = (reps == 4'd0) ? 4'd1 : reps;
                    step_d  = 2'd0;
                    rep_d   = 5'd1;
                    hold_d  = 8'd1;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (hold_q < HoldMax) begin
                    hold_d = hold_q + 8'd1;
                end else if (last_step) begin
                    state_d = StDone;
                end else if (GAP > 0) begin
                    gap_d   = 8'd1;
                    state_d = StGap;
                end else begin
                    step_d = step_adv;
                    rep_d  = rep_adv;
                    hold_d = 8'd1;
                end
            end
            StGap: begin
                if (gap_q < GapMax) begin
                    gap_d = gap_q + 8'd1;
                end else begin
                    step_d  = step_adv;
                    rep_d   = rep_adv;
                    hold_d  = 8'd1;
                    state_d = StEmit;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, so they are decoded from the next-state values
        out_code_d = 2'b00;
        if (state_d == StEmit) begin
            case (step_d)
                2'd0:    out_code_d = code0_d;
                2'd1:    out_code_d = code1_d;
                2'd2:    out_code_d = code2_d;
                default: out_code_d = 2'b00;
            endcase
        end
        code_valid_d = (state_d == StEmit) && (hold_d == 8'd1);
        busy_d       = (state_d == StEmit) || (state_d == StGap);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            code0_q    <= 2'b00;
            code1_q    <= 2'b00;
            code2_q    <= 2'b00;
            reps_q     <= 4'd0;
            step_q     <= 2'd0;
            rep_q      <= 5'd0;
            hold_q     <= 8'd0;
            gap_q      <= 8'd0;
            out_code   <= 2'b00;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            code0_q    <= code0_d;
            code1_q    <= code1_d;
            code2_q    <= code2_d;
            reps_q     <= reps_d;
            step_q     <= step_d;
            rep_q      <= rep_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            out_code   <= out_code_d;
            code_valid <= code_valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_gerador_sequencia_lampadas.sv
// Scoreboard bench: two generators (default timing and HOLD=3/GAP=2) share stimulus; a trace
// model queues the expected per-cycle outputs and a negedge monitor compares them.
module tb_gerador_sequencia_lampadas;

    typedef logic [4:0] obs_t;  // {out_code, code_valid, busy, done}
    typedef obs_t obs_q_t[$];

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] code0, code1, code2;
    logic [3:0] reps;

    logic [1:0] out_a, out_b;
    logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    int n_cmp = 0;
    int n_err = 0;

    obs_q_t fut_a, fut_b;  // remaining trace of the run in progress
    obs_q_t exp_a, exp_b;  // scoreboard: expected output for the current cycle

    gerador_sequencia_lampadas u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .code0      (code0),
        .code1      (code1),
        .code2      (code2),
        .reps       (reps),
        .out_code   (out_a),
        .code_valid (valid_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    gerador_sequencia_lampadas #(
        .HOLD (3),
        .GAP  (2)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .code0      (code0),
        .code1      (code1),
        .code2      (code2),
        .reps       (reps),
        .out_code   (out_b),
        .code_valid (valid_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole observable trace of one run, from the cycle after start through the idle cycle
    function automatic obs_q_t build_run(input int hold, input int gap, input logic [1:0] c0,
                                         input logic [1:0] c1, input logic [1:0] c2,
                                         input int r);
        obs_q_t     q;
        logic [1:0] cs[3];
        int         r_eff;
        cs[0] = c0;
        cs[1] = c1;
        cs[2] = c2;
        r_eff = (r == 0) ? 1 : r;
        for (int i = 0; i < r_eff; i++) begin
            for (int s = 0; s < 3; s++) begin
                if (i != 0 || s != 0) begin
                    for (int g = 0; g < gap; g++) q.push_back(5'b00_0_1_0);
                end
                for (int h = 0; h < hold; h++) q.push_back({cs[s], 1'(h == 0), 1'b1, 1'b0});
            end
        end
        q.push_back(5'b00_0_0_1);
        q.push_back(5'b00_0_0_0);
        return q;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got code=%b valid=%b busy=%b done=%b, expected code=%b valid=%b busy=%b done=%b",
                     name, $time, got[4:3], got[2], got[1], got[0],
                     want[4:3], want[2], want[1], want[0]);
        end
    endtask

    // One clock cycle of stimulus; the expected response is queued just after the edge
    task automatic cycle(input logic s, input logic [1:0] c0, input logic [1:0] c1,
                         input logic [1:0] c2, input logic [3:0] r);
        obs_t ea, eb;
        start = s;
        code0 = c0;
        code1 = c1;
        code2 = c2;
        reps  = r;
        if (fut_a.size() == 0 && s) fut_a = build_run(1, 0, c0, c1, c2, int'(r));
        if (fut_b.size() == 0 && s) fut_b = build_run(3, 2, c0, c1, c2, int'(r));
        ea = '0;
        eb = '0;
        if (fut_a.size() > 0) ea = fut_a.pop_front();
        if (fut_b.size() > 0) eb = fut_b.pop_front();
        @(posedge clk);
        #1;
        exp_a.push_back(ea);
        exp_b.push_back(eb);
    endtask

    task automatic drain();
        while (fut_a.size() > 0 || fut_b.size() > 0)
            cycle(1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
        cycle(1'b0, 2'b00, 2'b00, 2'b00, 4'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, {out_a, valid_a, busy_a, done_a}, 5'b0);
        check({tag, "_b"}, {out_b, valid_b, busy_b, done_b}, 5'b0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_a.size() > 0) check("trace_a", {out_a, valid_a, busy_a, done_a},
                                        exp_a.pop_front());
            if (exp_b.size() > 0) check("trace_b", {out_b, valid_b, busy_b, done_b},
                                        exp_b.pop_front());
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        code0 = 2'b00;
        code1 = 2'b00;
        code2 = 2'b00;
        reps  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
        cycle(1'b0, 2'b00, 2'b00, 2'b00, 4'd0);

        // Single run, codes 01/10/11
        cycle(1'b1, 2'b01, 2'b10, 2'b11, 4'd1);
        drain();

        // Two repetitions; mid-run start and code changes must be ignored
        cycle(1'b1, 2'b01, 2'b10, 2'b11, 4'd2);
        repeat (4) cycle(1'b0, 2'b01, 2'b10, 2'b11, 4'd2);
        cycle(1'b1, 2'b11, 2'b11, 2'b11, 4'd5);
        repeat (3) cycle(1'b0, 2'b11, 2'b11, 2'b11, 4'd5);
        drain();

        // Asynchronous reset during the second code step
        cycle(1'b1, 2'b10, 2'b01, 2'b11, 4'd1);
        cycle(1'b0, 2'b10, 2'b01, 2'b11, 4'd1);
        exp_a.delete();
        exp_b.delete();
        fut_a.delete();
        fut_b.delete();
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_held");
        reset = 1'b1;
        repeat (3) cycle(1'b0, 2'b00, 2'b00, 2'b00, 4'd0);
        cycle(1'b1, 2'b10, 2'b01, 2'b11, 4'd1);
        drain();

        // reps=0 plays once; code 00 is a real step
        cycle(1'b1, 2'b01, 2'b00, 2'b11, 4'd0);
        drain();

        // start held high: back-to-back runs with one idle cycle between
        repeat (12) cycle(1'b1, 2'b01, 2'b10, 2'b11, 4'd1);
        drain();

        // Maximum repetition count
        cycle(1'b1, 2'b11, 2'b01, 2'b10, 4'd15);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom), 2'($urandom),
                  4'($urandom_range(0, 3)));
        drain();
        cycle(1'b0, 2'b00, 2'b00, 2'b00, 4'd0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
